// File: rtl/pool2_seq_if.sv
// Bus bundle for pool2_seq: control, fmap-buffer read port and pooled-row write handshake.
// master = sequencer side, slave = buffers / controller side.
interface pool2_seq_if #(
  parameter int CHANNELS = 20,
  parameter int IN_DIM   = 24
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int RA_W    = $clog2(CHANNELS * IN_DIM);
  localparam int WA_W    = $clog2(CHANNELS * OUT_DIM);

  logic               start;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [RA_W-1:0]    rd_addr;
  logic [IN_DIM-1:0]  rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [WA_W-1:0]    out_addr;
  logic [OUT_DIM-1:0] out_data;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_en, rd_addr, out_valid, out_addr, out_data
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/pool2_seq.sv
// Time-multiplexed binary 2x2 max-pool sequencer: one OR engine walks every channel/output row.
// Optional POOL2_SEQ_PERF_EN adds a saturating 16-bit output-stall counter port stall_cnt.
module pool2_seq #(
  parameter int CHANNELS = 20,
  parameter int IN_DIM   = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  pool2_seq_if.master  bus
`ifdef POOL2_SEQ_PERF_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int RA_W    = $clog2(CHANNELS * IN_DIM);
  localparam int WA_W    = $clog2(CHANNELS * OUT_DIM);
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OR_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  generate
    if ((IN_DIM % 2) != 0) begin : g_dim_check
      $error("pool2_seq: IN_DIM must be even");
    end
  endgenerate

  // Binary max over each 2x2 window reduces to an OR of the four pixels.
  function automatic logic [OUT_DIM-1:0] pool_rows(input logic [IN_DIM-1:0] a,
                                                   input logic [IN_DIM-1:0] b);
    logic [OUT_DIM-1:0] r;
    r = '0;
    for (int j = 0; j < OUT_DIM; j++) begin
      r[j] = a[2*j] | a[2*j+1] | b[2*j] | b[2*j+1];
    end
    return r;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [OR_W-1:0]   orow_q, orow_d;
  logic [IN_DIM-1:0] rowa_q, rowa_d;
  logic [IN_DIM-1:0] rowb_q, rowb_d;
  logic              last_orow, last_ch;

  assign last_orow = (orow_q == OR_W'(OUT_DIM - 1));
  assign last_ch   = (ch_q == CH_W'(CHANNELS - 1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    orow_d  = orow_q;
    rowa_d  = rowa_q;
    rowb_d  = rowb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RD_A;
          ch_d    = '0;
          orow_d  = '0;
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        rowa_d  = bus.rd_data;
        state_d = S_CAP;
      end
      S_CAP: begin
        rowb_d  = bus.rd_data;
        state_d = S_WR;
      end
      S_WR: begin
        if (bus.out_ready) begin
          state_d = S_RD_A;
          if (last_orow) begin
            orow_d = '0;
            if (last_ch) begin
              ch_d    = '0;
              state_d = S_DONE;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            orow_d = orow_q + OR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      orow_q  <= '0;
      rowa_q  <= '0;
      rowb_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      orow_q  <= orow_d;
      rowa_q  <= rowa_d;
      rowb_q  <= rowb_d;
    end
  end

  // Outputs decode registered state only, so they stay stable across a stalled write.
  logic [RA_W-1:0] rd_base;
  assign rd_base = RA_W'(ch_q) * RA_W'(IN_DIM) + (RA_W'(orow_q) << 1);

  assign bus.busy      = (state_q == S_RD_A) || (state_q == S_RD_B) ||
                         (state_q == S_CAP)  || (state_q == S_WR);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = (state_q == S_RD_A) || (state_q == S_RD_B);
  assign bus.rd_addr   = rd_base + RA_W'(state_q == S_RD_B);
  assign bus.out_valid = (state_q == S_WR);
  assign bus.out_addr  = WA_W'(ch_q) * WA_W'(OUT_DIM) + WA_W'(orow_q);
  assign bus.out_data  = pool_rows(rowa_q, rowb_q);

`ifdef POOL2_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && bus.start) begin
      stall_d = '0;
    end else if ((state_q == S_WR) && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif
endmodule
